// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus between the MEM stage and the data memory.
interface mem_access_unit_if;
  logic        DMEM_req;
  logic        DMEM_we;
  logic [31:0] DMEM_addr;
  logic [31:0] DMEM_wdata;
  logic [3:0]  DMEM_byte_en;
  logic [31:0] DMEM_rdata;
  logic        DMEM_ack;

  modport master (
    output DMEM_req, DMEM_we, DMEM_addr, DMEM_wdata, DMEM_byte_en,
    input  DMEM_rdata, DMEM_ack
  );

  modport slave (
    input  DMEM_req, DMEM_we, DMEM_addr, DMEM_wdata, DMEM_byte_en,
    output DMEM_rdata, DMEM_ack
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: issues loads/stores over a req/ack bus, extends load data,
// stalls the front end while an access is outstanding, and registers MEM/WB outputs.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic [31:0]              IN_alu_result,
  input  logic [31:0]              IN_store_data,
  input  logic [2:0]               IN_funct3,
  input  logic                     IN_mem_read,
  input  logic                     IN_mem_write,
  input  logic [4:0]               IN_write_addr,
  input  logic                     IN_wbsel,
  input  logic                     IN_reg_write_en,
  mem_access_unit_if.master        dmem,
  output logic                     STALL,
  output logic [31:0]              OUT_load_data,
  output logic [31:0]              OUT_alu_result,
  output logic [4:0]               OUT_write_addr,
  output logic                     OUT_wbsel,
  output logic                     OUT_reg_write_en,
  output logic                     OUT_access_fault,
  output logic                     OUT_bus_err
);

  localparam int unsigned CNT_W     = 8;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [4:0]         rd_q, rd_d;
  logic               wbsel_q, wbsel_d;
  logic               we_q, we_d;
  logic               en_q, en_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        load_q, load_d;
  logic [31:0]        alu_q, alu_d;
  logic [4:0]         wa_q, wa_d;
  logic               owbsel_q, owbsel_d;
  logic               rwe_q, rwe_d;
  logic               afault_q, afault_d;
  logic               berr_q, berr_d;

  logic               mem_op, fault, f3_ok, misaligned;
  logic [CNT_W-1:0]   cnt_inc;
  logic [31:0]        lane_b, lane_h, load_ext;

  // Request legality of the instruction currently in EX/MEM
  always_comb begin
    mem_op     = IN_mem_read | IN_mem_write;
    f3_ok      = IN_mem_write ? (~IN_funct3[2] & (IN_funct3[1:0] != 2'b11))
                              : (IN_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned = ((IN_funct3[1:0] == 2'b01) & IN_alu_result[0]) |
                 ((IN_funct3[1:0] == 2'b10) & (|IN_alu_result[1:0]));
    fault      = mem_op & ((IN_mem_read & IN_mem_write) | ~f3_ok | misaligned);
  end

  assign STALL = ((state_q == IDLE) & mem_op & ~fault) | ((state_q == BUSY) & ~dmem.DMEM_ack);

  // Bus drive decoded from the latched request
  always_comb begin
    dmem.DMEM_req   = (state_q == BUSY);
    dmem.DMEM_we    = we_q;
    dmem.DMEM_addr  = {addr_q[31:2], 2'b00};
    dmem.DMEM_wdata = data_q;
    dmem.DMEM_byte_en = 4'hF;
    if (we_q) begin
      unique case (funct3_q[1:0])
        2'b00: begin
          dmem.DMEM_byte_en = 4'b0001 << addr_q[1:0];
          dmem.DMEM_wdata   = {4{data_q[7:0]}};
        end
        2'b01: begin
          dmem.DMEM_byte_en = 4'b0011 << {addr_q[1], 1'b0};
          dmem.DMEM_wdata   = {2{data_q[15:0]}};
        end
        default: begin
          dmem.DMEM_byte_en = 4'hF;
          dmem.DMEM_wdata   = data_q;
        end
      endcase
    end
  end

  // Lane select and sign/zero extension of the returned word
  always_comb begin
    lane_b   = dmem.DMEM_rdata >> {addr_q[1:0], 3'b000};
    lane_h   = dmem.DMEM_rdata >> {addr_q[1], 4'b0000};
    load_ext = dmem.DMEM_rdata;
    unique case (funct3_q[1:0])
      2'b00:   load_ext = {{24{lane_b[7]  & ~funct3_q[2]}}, lane_b[7:0]};
      2'b01:   load_ext = {{16{lane_h[15] & ~funct3_q[2]}}, lane_h[15:0]};
      default: load_ext = dmem.DMEM_rdata;
    endcase
  end

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state and MEM/WB result logic
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    funct3_d = funct3_q;
    rd_d     = rd_q;
    wbsel_d  = wbsel_q;
    we_d     = we_q;
    en_d     = en_q;
    cnt_d    = cnt_q;
    load_d   = load_q;
    alu_d    = alu_q;
    wa_d     = wa_q;
    owbsel_d = owbsel_q;
    rwe_d    = 1'b0;
    afault_d = 1'b0;
    berr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        alu_d    = IN_alu_result;
        wa_d     = IN_write_addr;
        owbsel_d = IN_wbsel;
        load_d   = '0;
        if (!mem_op) begin
          rwe_d = IN_reg_write_en;
        end else if (fault) begin
          afault_d = 1'b1;
        end else begin
          state_d  = BUSY;
          addr_d   = IN_alu_result;
          data_d   = IN_store_data;
          funct3_d = IN_funct3;
          rd_d     = IN_write_addr;
          wbsel_d  = IN_wbsel;
          we_d     = IN_mem_write;
          en_d     = IN_reg_write_en;
          cnt_d    = '0;
        end
      end
      BUSY: begin
        if (dmem.DMEM_ack) begin
          state_d  = IDLE;
          alu_d    = addr_q;
          wa_d     = rd_q;
          owbsel_d = wbsel_q;
          rwe_d    = en_q;
          load_d   = we_q ? 32'h0 : load_ext;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= TIMEOUT_C) begin
            state_d  = IDLE;
            berr_d   = 1'b1;
            alu_d    = addr_q;
            wa_d     = rd_q;
            owbsel_d = wbsel_q;
            load_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      funct3_q <= '0;
      rd_q     <= '0;
      wbsel_q  <= 1'b0;
      we_q     <= 1'b0;
      en_q     <= 1'b0;
      cnt_q    <= '0;
      load_q   <= '0;
      alu_q    <= '0;
      wa_q     <= '0;
      owbsel_q <= 1'b0;
      rwe_q    <= 1'b0;
      afault_q <= 1'b0;
      berr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      wbsel_q  <= wbsel_d;
      we_q     <= we_d;
      en_q     <= en_d;
      cnt_q    <= cnt_d;
      load_q   <= load_d;
      alu_q    <= alu_d;
      wa_q     <= wa_d;
      owbsel_q <= owbsel_d;
      rwe_q    <= rwe_d;
      afault_q <= afault_d;
      berr_q   <= berr_d;
    end
  end

  assign OUT_load_data    = load_q;
  assign OUT_alu_result   = alu_q;
  assign OUT_write_addr   = wa_q;
  assign OUT_wbsel        = owbsel_q;
  assign OUT_reg_write_en = rwe_q;
  assign OUT_access_fault = afault_q;
  assign OUT_bus_err      = berr_q;

endmodule
